// File: rtl/div_pkg.sv
// Shared types and constants for the sequential signed restoring divider.
// Operand width and the fixed Start-to-results latency live here.
package div_pkg;

  localparam int DIV_N       = 8;
  localparam int DIV_LATENCY = 10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    ITER = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {P,Q} left, trial-subtract
// the divisor magnitude, keep the difference or restore, and shift in the quotient bit.
module div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  output logic [N-1:0] p_nxt,
  output logic [N-1:0] q_nxt
);

  logic [N:0] p_sh;
  logic [N:0] trial;

  assign p_sh = {p, q[N-1]};

  nine_bit_adder u_sub (
    .a   (p_sh),
    .b   (~{1'b0, d}),
    .cin (1'b1),
    .sum (trial)
  );

  // The kept remainder is always below |d| <= 2^(N-1), so bit N of the
  // partial remainder is zero between steps and need not be stored.
  assign p_nxt = trial[N] ? p_sh[N-1:0] : trial[N-1:0];
  assign q_nxt = {q[N-2:0], ~trial[N]};

endmodule

// File: rtl/nine_bit_adder.sv
// Nine-bit ripple-carry adder shared by the arithmetic unit.
// Subtraction is done by the caller: invert b and set cin.
module nine_bit_adder (
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic       cin,
  output logic [8:0] sum
);

  logic [8:0] carry;

  assign carry[0] = cin;

  for (genvar gi = 0; gi < 9; gi++) begin : g_bit
    assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
    if (gi < 8) begin : g_carry
      assign carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential signed restoring divider: latches operands on Start, iterates N
// restoring steps on magnitudes, then applies signs and special cases.
//
// state | meaning
// IDLE  | waiting for Start; operands latched on the accepting edge
// PREP  | take magnitudes, record signs, clear partial remainder, load counter
// ITER  | one restoring step per cycle, N cycles via down-counter
// FIX   | sign-correct and register Quotient/Remainder/DivZero/Ovf
// DONE  | Done pulse for one cycle, then back to IDLE
module seq_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] Dividend,
  input  logic [N-1:0] Divisor,
  output logic [N-1:0] Quotient,
  output logic [N-1:0] Remainder,
  output logic         Busy,
  output logic         Done,
  output logic         DivZero,
  output logic         Ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  div_state_e state_q, state_d;

  logic [N-1:0]  a_q, b_q;
  logic [N-1:0]  mag_b;
  logic [N-1:0]  p_r, q_r;
  logic [N-1:0]  p_nxt, q_nxt;
  logic          q_neg, r_neg;
  logic [CW-1:0] cnt;

  logic          div_zero, div_ovf;
  logic [N-1:0]  q_signed, r_signed;

  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v);
    return v[N-1] ? (~v + 1'b1) : v;
  endfunction

  div_step #(.N(N)) u_step (
    .p     (p_r),
    .q     (q_r),
    .d     (mag_b),
    .p_nxt (p_nxt),
    .q_nxt (q_nxt)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Busy    = 1'b1;
    Done    = 1'b0;
    case (state_q)
      IDLE: begin
        Busy = 1'b0;
        if (Start) state_d = PREP;
      end
      PREP: state_d = ITER;
      ITER: if (cnt == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: begin
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        Busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign div_zero = (b_q == '0);
  assign div_ovf  = (a_q == {1'b1, {(N-1){1'b0}}}) && (b_q == '1);
  assign q_signed = q_neg ? (~q_r + 1'b1) : q_r;
  assign r_signed = r_neg ? (~p_r + 1'b1) : p_r;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      a_q       <= '0;
      b_q       <= '0;
      mag_b     <= '0;
      p_r       <= '0;
      q_r       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      DivZero   <= 1'b0;
      Ovf       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            a_q <= Dividend;
            b_q <= Divisor;
          end
        end
        PREP: begin
          q_r   <= magnitude(a_q);
          mag_b <= magnitude(b_q);
          p_r   <= '0;
          q_neg <= a_q[N-1] ^ b_q[N-1];
          r_neg <= a_q[N-1];
          cnt   <= CW'(N - 1);
        end
        ITER: begin
          p_r <= p_nxt;
          q_r <= q_nxt;
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIX: begin
          DivZero <= div_zero;
          Ovf     <= div_ovf;
          if (div_zero) begin
            Quotient  <= '1;
            Remainder <= a_q;
          end else if (div_ovf) begin
            Quotient  <= {1'b1, {(N-1){1'b0}}};
            Remainder <= '0;
          end else begin
            Quotient  <= q_signed;
            Remainder <= r_signed;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results per
// accepted Start, and a monitor compares them whenever Done is seen.
module tb_seq_divider;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic [7:0] Dividend, Divisor;
  logic [7:0] Quotient, Remainder;
  logic       Busy, Done, DivZero, Ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
    int         t;
  } exp_t;

  exp_t sb[$];

  seq_divider dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Busy      (Busy),
    .Done      (Done),
    .DivZero   (DivZero),
    .Ovf       (Ovf)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset && Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got Done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient",  {24'd0, Quotient},  {24'd0, e.q});
        chk("remainder", {24'd0, Remainder}, {24'd0, e.r});
        chk("divzero",   {31'd0, DivZero},   {31'd0, e.dz});
        chk("ovf",       {31'd0, Ovf},       {31'd0, e.ov});
        chk("latency",   cyc - e.t,          div_pkg::DIV_LATENCY);
      end
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic eov,
                        input bit chk_busy, input bit inject);
    exp_t e;
    @(negedge Clk);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    e.q = eq; e.r = er; e.dz = edz; e.ov = eov; e.t = cyc + 1;
    sb.push_back(e);
    for (int i = 0; i < 11; i++) begin
      @(negedge Clk);
      Start    = 1'b0;
      Dividend = 8'h5A;
      Divisor  = 8'hC3;
      if (chk_busy) chk("busy_active", {31'd0, Busy}, 32'd1);
      if (inject && i == 3) begin
        Start    = 1'b1;
        Dividend = 8'd50;
        Divisor  = 8'd5;
      end
    end
    @(negedge Clk);
    Start = 1'b0;
    if (chk_busy) chk("busy_idle", {31'd0, Busy}, 32'd0);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_quotient"},  {24'd0, Quotient},  32'd0);
    chk({tag, "_remainder"}, {24'd0, Remainder}, 32'd0);
    chk({tag, "_busy"},      {31'd0, Busy},      32'd0);
    chk({tag, "_done"},      {31'd0, Done},      32'd0);
    chk({tag, "_divzero"},   {31'd0, DivZero},   32'd0);
    chk({tag, "_ovf"},       {31'd0, Ovf},       32'd0);
  endtask

  initial begin
    Reset    = 1'b1;
    Start    = 1'b0;
    Dividend = 8'h00;
    Divisor  = 8'h00;
    repeat (2) @(negedge Clk);
    chk_cleared("reset");
    Reset = 1'b0;

    run_op(8'h64, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    run_op(8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'h05, 8'h00, 8'hFF, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op(8'h14, 8'h03, 8'h06, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1);

    // Abandoned operation: nothing is queued, so any Done from it is flagged.
    @(negedge Clk);
    Dividend = 8'h64;
    Divisor  = 8'h07;
    Start    = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (5) @(posedge Clk);
    #2 Reset = 1'b1;
    #1 chk_cleared("midreset");
    repeat (2) @(negedge Clk);
    Reset = 1'b0;

    run_op(8'h09, 8'h04, 8'h02, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);

    repeat (3) @(negedge Clk);
    chk("pending_results", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
